// File: rtl/mmio_pkg.sv
// -----------------------------------------------------------------------------
// mmio_pkg
// Shared definitions for the MMIO fabric: FSM state type, the read data
// returned on a bus error, the default 4-slot address map, and a helper for
// sizing the slot index.
// -----------------------------------------------------------------------------
package mmio_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Returned on req_rdata when a request ends in decode miss or timeout.
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    // Default map, slot 0 in the LSBs. Slots 0 and 1 overlap on purpose;
    // the lowest index wins, so slot 1 is only reachable by overriding.
    localparam logic [127:0] DEF_SLV_BASE = {
        32'h0000_0900, 32'h0000_0800, 32'h0000_0000, 32'h0000_0000
    };
    localparam logic [127:0] DEF_SLV_MASK = {
        32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FF00, 32'hFFFF_FF00
    };

    // Width of a slot index; never zero so a 1-slot build still has a bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mmio_decode.sv
// -----------------------------------------------------------------------------
// mmio_decode
// Combinational address decoder. Slot i matches when
// (addr & mask[i]) == base[i]; the lowest matching index wins.
//   addr  in   32-bit byte address
//   hit   out  at least one slot matched
//   slot  out  index of the winning slot (0 when no hit)
// -----------------------------------------------------------------------------
module mmio_decode
    import mmio_pkg::*;
#(
    parameter int                    NUM_SLV  = 4,
    parameter logic [NUM_SLV*32-1:0] SLV_BASE = DEF_SLV_BASE,
    parameter logic [NUM_SLV*32-1:0] SLV_MASK = DEF_SLV_MASK,
    localparam int                   SW       = idx_width(NUM_SLV)
) (
    input  logic [31:0]   addr,
    output logic          hit,
    output logic [SW-1:0] slot
);

    // NOTE: every output of an always_comb gets a default first, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        hit  = 1'b0;
        slot = '0;
        // Walk from the top down so the lowest matching index is written last.
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32]) begin
                hit  = 1'b1;
                slot = SW'(i);
            end
        end
    end

endmodule

// File: rtl/mmio_fabric.sv
// -----------------------------------------------------------------------------
// mmio_fabric
// Single-master MMIO fabric: decodes a CPU request onto one of NUM_SLV slave
// ports, waits for that slave's ack (bounded by TIMEOUT cycles), and returns a
// one-cycle response. Decode misses and timeouts return ERR_DATA with req_err
// and are logged in a sticky error register holding the first failing address.
//   clk, reset             clock, synchronous active-high reset
//   req_valid/we/addr/wdata CPU request, held until req_ready
//   req_ready/rdata/err    one-cycle response strobe, data, error flag
//   slv_sel/we/addr/wdata  one-hot select and latched request, during ACCESS
//   slv_rdata/slv_ack      per-slot read data and completion
//   err_valid/err_addr     sticky error flag and first error address
//   err_clr                clears err_valid
// -----------------------------------------------------------------------------
module mmio_fabric
    import mmio_pkg::*;
#(
    parameter int                    NUM_SLV  = 4,
    parameter int                    DW       = 32,
    parameter logic [NUM_SLV*32-1:0] SLV_BASE = DEF_SLV_BASE,
    parameter logic [NUM_SLV*32-1:0] SLV_MASK = DEF_SLV_MASK,
    parameter int                    TIMEOUT  = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [DW-1:0]         req_wdata,
    output logic                  req_ready,
    output logic [DW-1:0]         req_rdata,
    output logic                  req_err,
    output logic [NUM_SLV-1:0]    slv_sel,
    output logic                  slv_we,
    output logic [31:0]           slv_addr,
    output logic [DW-1:0]         slv_wdata,
    input  logic [NUM_SLV*DW-1:0] slv_rdata,
    input  logic [NUM_SLV-1:0]    slv_ack,
    output logic                  err_valid,
    output logic [31:0]           err_addr,
    input  logic                  err_clr
);

    localparam int            SW       = idx_width(NUM_SLV);
    localparam logic [DW-1:0] ERR_WORD = DW'(ERR_DATA);
    localparam logic [7:0]    CNT_LAST = 8'(TIMEOUT - 1);

    state_t        state, state_nxt;
    logic [7:0]    cnt;
    logic [SW-1:0] slot_q;
    logic          we_q;
    logic          err_q;

    logic          dec_hit;
    logic [SW-1:0] dec_slot;
    logic          sel_ack;
    logic          cnt_done;
    logic          new_err;
    logic [31:0]   new_err_addr;

    mmio_decode #(
        .NUM_SLV  (NUM_SLV),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_decode (
        .addr (req_addr),
        .hit  (dec_hit),
        .slot (dec_slot)
    );

    // Only the selected slot's ack is looked at; other ack bits are noise.
    assign sel_ack  = slv_ack[slot_q];
    assign cnt_done = (cnt == CNT_LAST);

    // ---------------------------------------------------------------- FSM
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order. The synchronous
    // reset is tested first, so a slave ack in the reset cycle is discarded.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        slv_sel   = '0;
        slv_we    = 1'b0;
        req_ready = 1'b0;
        req_err   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) state_nxt = dec_hit ? ACCESS : RESP;
            end
            ACCESS: begin
                slv_sel[slot_q] = 1'b1;
                slv_we          = we_q;
                if (sel_ack || cnt_done) state_nxt = RESP;
            end
            RESP: begin
                req_ready = 1'b1;
                req_err   = err_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Error events: decode miss on acceptance, or the last ACCESS cycle
    // passing without an ack.
    always_comb begin
        new_err      = 1'b0;
        new_err_addr = slv_addr;
        if (state == IDLE && req_valid && !dec_hit) begin
            new_err      = 1'b1;
            new_err_addr = req_addr;
        end else if (state == ACCESS && !sel_ack && cnt_done) begin
            new_err = 1'b1;
        end
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            slot_q    <= '0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            slv_addr  <= '0;
            slv_wdata <= '0;
            req_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (req_valid) begin
                        if (dec_hit) begin
                            slot_q    <= dec_slot;
                            we_q      <= req_we;
                            slv_addr  <= req_addr;
                            slv_wdata <= req_wdata;
                        end else begin
                            err_q     <= 1'b1;
                            req_rdata <= ERR_WORD;
                        end
                    end
                end
                ACCESS: begin
                    if (sel_ack) begin
                        err_q     <= 1'b0;
                        req_rdata <= slv_rdata[int'(slot_q)*DW +: DW];
                    end else if (cnt_done) begin
                        err_q     <= 1'b1;
                        req_rdata <= ERR_WORD;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky error log: the first error is kept; a new error in the same
    // cycle as err_clr replaces the logged one.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
        end else if (new_err && (!err_valid || err_clr)) begin
            err_valid <= 1'b1;
            err_addr  <= new_err_addr;
        end else if (err_clr) begin
            err_valid <= 1'b0;
        end
    end

endmodule

// File: doc/mmio_fabric.md
MMIO_FABRIC -- requirements
Module: mmio_fabric

Interface
REQ-001 Parameter NUM_SLV, default 4: number of memory-mapped slave ports, 1..8.
REQ-002 Parameter DW, default 32: data width; address width is fixed at 32.
REQ-003 Parameter SLV_BASE, default {0x900,0x800,0x000,0x000} (NUM_SLV*32 bits, slot 0 in LSBs): per-slot base address.
REQ-004 Parameter SLV_MASK, default {0xFFFFFFF0,0xFFFFFFF0,0xFFFFFF00,0xFFFFFF00}: per-slot compare mask.
REQ-005 Parameter TIMEOUT, default 15: ACCESS cycles without slave ack before a bus error, 1..255.
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 req_valid  in  1  CPU request pending; held with all req_* stable until req_ready.
REQ-009 req_we  in  1  1 = write, 0 = read.
REQ-010 req_addr  in  32  byte address.
REQ-011 req_wdata  in  DW  write data.
REQ-012 req_ready  out  1  one-cycle response strobe; completes the request.
REQ-013 req_rdata  out  DW  read data, valid when req_ready=1.
REQ-014 req_err  out  1  with req_ready: request ended in decode miss or timeout.
REQ-015 slv_sel  out  NUM_SLV  one-hot slave select, asserted during ACCESS.
REQ-016 slv_we  out  1  write enable, qualified by slv_sel.
REQ-017 slv_addr  out  32  latched request address.
REQ-018 slv_wdata  out  DW  latched write data.
REQ-019 slv_rdata  in  NUM_SLV*DW  per-slot read data, slot 0 in LSBs.
REQ-020 slv_ack  in  NUM_SLV  per-slot completion, sampled only for the selected slot.
REQ-021 err_valid  out  1  sticky error flag.
REQ-022 err_addr  out  32  address of the first unacknowledged error.
REQ-023 err_clr  in  1  clears err_valid.

Function
REQ-024 FSM states SHALL be IDLE, ACCESS, RESP.
REQ-025 In IDLE with req_valid=1, slot i SHALL match when (req_addr & SLV_MASK[i]) == SLV_BASE[i]; the lowest matching index wins.
REQ-026 On a match, the block SHALL latch addr, we, wdata and the slot index, then enter ACCESS.
REQ-027 On no match, the block SHALL enter RESP with error and SHALL NOT assert slv_sel.
REQ-028 In ACCESS, slv_sel SHALL assert the one bit of the latched slot, with slv_we/slv_addr/slv_wdata driven from the latches.
REQ-029 In ACCESS, slv_ack of the selected slot SHALL capture that slot's slv_rdata and enter RESP with no error; ack bits of other slots SHALL be ignored.
REQ-030 An ACCESS cycle counter SHALL start at 0 on entry; ACCESS SHALL end when the count reaches TIMEOUT-1 without ack, entering RESP with error.
REQ-031 In RESP, req_ready SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-032 On error, req_rdata SHALL be ERR_DATA (0xDEADBEEF, truncated to DW) and req_err SHALL be 1.
REQ-033 Minimum latency SHALL be req_valid sampled in IDLE at cycle N, ack at N+1, req_ready at N+2; decode miss SHALL give req_ready at N+1.
REQ-034 A new request SHALL NOT be accepted in RESP; the earliest next acceptance is the cycle after RESP.
REQ-035 On any error, if err_valid=0, err_valid SHALL be set and err_addr loaded; if already set, err_addr SHALL hold the first error.
REQ-036 If err_clr and a new error occur in the same cycle, the new error SHALL win: err_valid=1 and err_addr = new address.
REQ-037 Outside RESP, req_rdata SHALL hold its last value.

Reset
REQ-038 Reset SHALL force IDLE, counter 0, slv_sel=0, slv_we=0, req_ready=0, req_err=0, req_rdata=0, slv_addr=0, slv_wdata=0, err_valid=0, err_addr=0.
REQ-039 Reset in ACCESS or RESP SHALL abort the transaction with no req_ready pulse; a slave ack in the reset cycle SHALL be ignored.

Structure
REQ-040 Package mmio_pkg SHALL hold the FSM state typedef, ERR_DATA, and the default SLV_BASE/SLV_MASK constants.
REQ-041 Address matching SHALL be a combinational sub-module mmio_decode (inputs: addr; outputs: hit, slot index), parameterised like mmio_fabric.

Verification
REQ-042 Read 0x804, slot 2 acks at first ACCESS cycle with rdata 0x78 -> req_ready 2 cycles after acceptance, req_rdata=0x78, req_err=0.
REQ-043 Write 0x908 data 0x5, slot 3 acks after 3 wait cycles -> slv_sel=4'b1000 and slv_we=1 for 4 cycles, then one-cycle req_ready.
REQ-044 Read 0x1234 (no match) -> req_ready next cycle, req_rdata=0xDEADBEEF, req_err=1, err_addr=0x1234, slv_sel never asserted.
REQ-045 Read 0x800, slot 2 never acks, TIMEOUT=15 -> req_ready with req_err=1 after 15 ACCESS cycles; a second timeout at 0x900 leaves err_addr=0x800.
REQ-046 err_clr together with a decode miss at 0x2000 -> err_valid stays 1, err_addr=0x2000.
REQ-047 Reset asserted mid-ACCESS while slot 2 acks -> no req_ready pulse, all outputs at reset values the next cycle, and the next request is served normally.
